// File: rtl/vedic_mult_pipe.sv
// Pipelined NxN Urdhva-Tiryagbhyam multiplier with a signed mode and a valid/ready handshake.
// vedic_mul is the recursive combinational core; vedic_mult_pipe wraps it in three stall-able stages.
module vedic_mul #(
  parameter int W = 2
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  generate
    if (W == 2) begin : g_leaf
      // 2x2 vertical-and-crosswise cell: the cross term carries into the top column.
      logic c_s;
      assign c_s  = (a[1] & b[0]) & (a[0] & b[1]);
      assign p[0] = a[0] & b[0];
      assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
      assign p[2] = (a[1] & b[1]) ^ c_s;
      assign p[3] = (a[1] & b[1]) & c_s;
    end else begin : g_split
      localparam int H = W / 2;
      logic [W-1:0]   ll_s;
      logic [W-1:0]   lh_s;
      logic [W-1:0]   hl_s;
      logic [W-1:0]   hh_s;
      logic [2*W-1:0] mid_s;

      vedic_mul #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll_s));
      vedic_mul #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh_s));
      vedic_mul #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl_s));
      vedic_mul #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh_s));

      assign mid_s = {{W{1'b0}}, lh_s} + {{W{1'b0}}, hl_s};
      assign p     = {hh_s, ll_s} + (mid_s << H);
    end
  endgenerate

endmodule

module vedic_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_p
);

  localparam int HALF = WIDTH / 2;

  // Magnitude in WIDTH unsigned bits; the most negative value maps onto 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    if (sgn && x[WIDTH-1]) begin
      magnitude = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = x;
    end
  endfunction

  logic             adv_s;
  logic             v1_r;
  logic             v2_r;
  logic [WIDTH-1:0] ma_r;
  logic [WIDTH-1:0] mb_r;
  logic             neg1_r;
  logic             neg2_r;
  logic [WIDTH-1:0] ll_s;
  logic [WIDTH-1:0] lh_s;
  logic [WIDTH-1:0] hl_s;
  logic [WIDTH-1:0] hh_s;
  logic [WIDTH-1:0] ll_r;
  logic [WIDTH-1:0] lh_r;
  logic [WIDTH-1:0] hl_r;
  logic [WIDTH-1:0] hh_r;
  logic [OUT_W-1:0] op0_s;
  logic [OUT_W-1:0] op1_s;
  logic [OUT_W-1:0] op2_s;
  logic [OUT_W-1:0] sum_s;
  logic [OUT_W-1:0] maj_s;
  logic [OUT_W-1:0] prod_s;
  logic [OUT_W-1:0] res_s;

  assign adv_s    = ~out_valid | out_ready;
  assign in_ready = adv_s;

  vedic_mul #(.W(HALF)) u_ll (.a(ma_r[HALF-1:0]),     .b(mb_r[HALF-1:0]),     .p(ll_s));
  vedic_mul #(.W(HALF)) u_lh (.a(ma_r[HALF-1:0]),     .b(mb_r[WIDTH-1:HALF]), .p(lh_s));
  vedic_mul #(.W(HALF)) u_hl (.a(ma_r[WIDTH-1:HALF]), .b(mb_r[HALF-1:0]),     .p(hl_s));
  vedic_mul #(.W(HALF)) u_hh (.a(ma_r[WIDTH-1:HALF]), .b(mb_r[WIDTH-1:HALF]), .p(hh_s));

  // LL and HH never overlap, so they share one CSA operand; a 3:2 layer then a CPA suffices.
  always_comb begin
    op0_s  = {hh_r, ll_r};
    op1_s  = {{HALF{1'b0}}, lh_r, {HALF{1'b0}}};
    op2_s  = {{HALF{1'b0}}, hl_r, {HALF{1'b0}}};
    sum_s  = op0_s ^ op1_s ^ op2_s;
    maj_s  = (op0_s & op1_s) | (op0_s & op2_s) | (op1_s & op2_s);
    prod_s = sum_s + {maj_s[OUT_W-2:0], 1'b0};
    if (neg2_r) begin
      res_s = ~prod_s + {{(OUT_W-1){1'b0}}, 1'b1};
    end else begin
      res_s = prod_s;
    end
  end

  // All three stages advance together on adv_s and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r      <= 1'b0;
      ma_r      <= {WIDTH{1'b0}};
      mb_r      <= {WIDTH{1'b0}};
      neg1_r    <= 1'b0;
      v2_r      <= 1'b0;
      ll_r      <= {WIDTH{1'b0}};
      lh_r      <= {WIDTH{1'b0}};
      hl_r      <= {WIDTH{1'b0}};
      hh_r      <= {WIDTH{1'b0}};
      neg2_r    <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= {OUT_W{1'b0}};
    end else if (adv_s) begin
      v1_r      <= in_valid & in_ready;
      ma_r      <= magnitude(in_a, in_signed);
      mb_r      <= magnitude(in_b, in_signed);
      neg1_r    <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      v2_r      <= v1_r;
      ll_r      <= ll_s;
      lh_r      <= lh_s;
      hl_r      <= hl_s;
      hh_r      <= hh_s;
      neg2_r    <= neg1_r;
      out_valid <= v2_r;
      out_p     <= res_s;
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench for vedic_mult_pipe (WIDTH=8): directed literals, stream, stall, reset, random.
module tb_vedic_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] q[$];
  logic        held_v = 1'b0;
  logic [15:0] held_p = 16'h0000;
  int          run = 0;
  int          max_run = 0;

  vedic_mult_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    longint x;
    longint y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return 16'(x * y);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: transfers are decided at the next posedge, so look at the settled values on negedge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      held_v = 1'b0;
      run    = 0;
    end else begin
      check("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (held_v) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_hold", {48'd0, out_p}, {48'd0, held_p});
      end
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", 64'd1, 64'd0);
        else check("product", {48'd0, out_p}, {48'd0, q.pop_front()});
      end
      held_v = out_valid && !out_ready;
      held_p = out_p;
      if (in_valid && in_ready) q.push_back(ref_mul(in_a, in_b, in_signed));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op_lit(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, input string nm);
    int lat;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    check({nm, "_lat"}, 64'(lat), 64'd3);
    check(nm, {48'd0, out_p}, {48'd0, exp});
    step();
  endtask

  task automatic drain();
    int i;
    in_valid = 1'b0;
    out_ready = 1'b1;
    i = 0;
    while (q.size() != 0 && i < 30) begin
      step();
      i++;
    end
    step();
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_signed = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_p", {48'd0, out_p}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    step(); step();
    rst = 1'b0;
    step();

    op_lit(8'd15, 8'd15, 1'b0, 16'h00E1, "u15x15");
    op_lit(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u255x255");
    op_lit(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5");
    op_lit(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128xm128");
    op_lit(8'h80, 8'h01, 1'b1, 16'hFF80, "s_m128x1");
    op_lit(8'h00, 8'hFF, 1'b1, 16'h0000, "s_zero");
    op_lit(8'h80, 8'h02, 1'b0, 16'h0100, "u_msb_set");

    // Back-to-back stream i*(i+1).
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      in_a = 8'(i); in_b = 8'(i + 1); in_signed = 1'(i % 2); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("stream_run", 64'(max_run), 64'd8);
    check("stream_empty", 64'(q.size()), 64'd0);

    // Fill, then stall for 5 cycles with new operands offered.
    for (int i = 0; i < 4; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_signed = 1'($urandom); in_valid = 1'b1;
      step();
    end
    out_ready = 1'b0;
    in_a = 8'h7F; in_b = 8'h81; in_signed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    drain();

    // Asynchronous reset mid-cycle with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      in_a = 8'(i + 3); in_b = 8'(i + 7); in_signed = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_out_p", {48'd0, out_p}, 64'd0);
    q.delete();
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_idle", {63'd0, out_valid}, 64'd0);
    end
    op_lit(8'd12, 8'd11, 1'b0, 16'd132, "post_rst_op");

    // Randomized traffic with random backpressure, biased toward corner operands.
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 5))
        0:       in_a = 8'h80;
        1:       in_a = 8'h00;
        2:       in_a = 8'hFF;
        default: in_a = 8'($urandom);
      endcase
      in_b      = ($urandom_range(0, 5) == 0) ? 8'h7F : 8'($urandom);
      in_signed = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vedic_mult_pipe.md
Name: vedic_mult_pipe

Overview:
- Parametrised, pipelined unsigned/signed NxN multiplier built on Urdhva-Tiryagbhyam (Vedic) decomposition.
- Recursively splits operands into halves, forms four half-width sub-products, and combines them with a carry-save adder stage.
- Generation after the fixed 4-bit combinational Vedic multiplier. Adds width generalisation, a signed mode, registered pipeline stages and a valid/ready handshake with backpressure.
- Sits between operand-producing datapath logic and accumulator/consumer blocks.

Parameters:
- WIDTH, 8, operand width in bits. Legal values are powers of two, at least 4; 2-bit base cell at the leaf.
- OUT_W, 2*WIDTH, product width; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair on in_a/in_b/in_signed is valid
- in_ready  output  1  block accepts operands this cycle
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands
- out_valid  output  1  out_p holds a valid product
- out_ready  input  1  consumer accepts product this cycle
- out_p  output  OUT_W  product (two's complement when the op was signed)

Behaviour:
- Reset (async assert, sync release on clk):
  - All stage valid bits are 0, so out_valid=0.
  - out_p=0 and in_ready=1.
  - Data registers are cleared to 0.
- Pipeline: 3 register stages; latency is exactly 3 cycles from accept to out_valid when not stalled.
  - S1: register a, b and the signed flag. Form magnitudes: if signed and MSB set, |x| = ~x+1, computed in WIDTH bits unsigned. |-2^(WIDTH-1)| = 2^(WIDTH-1) fits. Register neg = signed & (a[MSB]^b[MSB]).
  - S2: compute the four WIDTH/2 x WIDTH/2 Vedic sub-products LL, LH, HL, HH (recursive down to the 2x2 cell); register them along with neg.
  - S3: combine as P = LL + ((LH+HL) << WIDTH/2) + (HH << WIDTH) using a carry-save adder and a final carry-propagate adder. Result is OUT_W bits, no overflow possible. If neg, out_p = ~P+1 (OUT_W bits). Register into out_p.
- Handshake:
  - Transfer in occurs when in_valid & in_ready; transfer out occurs when out_valid & out_ready.
  - Global stall enable: adv = ~out_valid | out_ready; in_ready = adv (combinational from out_valid/out_ready only, no dependence on in_valid).
  - When adv=1 all stages shift. The S1 valid bit loads in_valid&in_ready.
  - When adv=0 every stage, including out_p and out_valid, holds its value.
  - While stalled, out_p is stable until accepted.
  - Bubbles are not collapsed: sustained throughput is 1 op/cycle with out_ready=1.
- Simultaneous accept and output transfer in the same cycle is legal and required at full throughput.
- in_signed=0: operands with the MSB set are treated as large unsigned values; no negation.
- Zero operand: product 0, and for signed ops no -0 artefacts (negating 0 gives 0).
- Reset mid-operation: all in-flight ops are discarded, out_valid drops asynchronously, and no stale product appears after release.
- No X propagation from data inputs when in_valid=0: the data registers may load, but valid bits stay 0.

Test Plan:
- WIDTH=8, unsigned, out_ready=1: a=15, b=15 -> out_valid exactly 3 cycles after accept, out_p=225 (0x00E1); a=255, b=255 -> 0xFE01.
- Signed: a=0xFD (-3), b=0x05 -> 0xFFF1 (-15); a=0x80, b=0x80 (-128*-128) -> 0x4000; a=0x80, b=0x01 -> 0xFF80.
- Back-to-back stream: 8 consecutive ops with i*(i+1) for i=0..7, mixed signed flag -> 8 consecutive out_valid cycles, products in order, none dropped or duplicated.
- Backpressure: hold out_ready=0 for 5 cycles with the pipeline full -> in_ready=0, out_p unchanged; on release, remaining ops drain in order.
- Reset: assert rst asynchronously mid-clock with 3 ops in flight -> out_valid=0 and out_p=0 immediately; after release, no product emerges until a new accept.
- Parameter sweep: WIDTH=4, 16, 32 with random operands vs a reference multiply (signed and unsigned), 10k ops each, with random out_ready -> zero mismatches.
